fifo_wr_arbiter: RTL

//  Shares the single write port of the FIFO between NUM_REQ requesters.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

  // Round-robin successor: the requester after idx, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
    return (idx == num_req - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_valid
);

  always_comb begin
    win_idx   = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && req[IDX_W'((32'(rr_ptr) + i) % NUM_REQ)]) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port; a winner owns it for up to MAX_BURST words.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters (stat_sel/stat_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  input  logic                     fifo_overflow,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     err_overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]         stat_sel,
  output logic [STAT_W-1:0]        stat_cnt
`endif
);

  localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [WIDTH-1:0]  data_arr [NUM_REQ];
  logic              in_burst;
  logic              owner_valid;
  logic              beat;
  logic              burst_done;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .win_idx   (pick_idx),
    .any_valid (pick_any)
  );

  assign in_burst    = (state_q == BURST);
  assign owner_valid = req_valid[grant_idx];
  assign beat        = in_burst & owner_valid & ~fifo_full;
  assign burst_done  = beat & (req_last[grant_idx] | (beat_cnt_q == BEAT_W'(MAX_BURST - 1)));
  assign grant_valid = in_burst;
  assign fifo_wr_en  = beat;

  // Write side is combinational so the FIFO captures the beat on the same edge.
  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    if (in_burst) begin
      req_ready[grant_idx] = ~fifo_full;
      fifo_wdata           = data_arr[grant_idx];
    end
  end

  // Grant FSM; a full stall holds the grant, a dropped valid releases it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_idx  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_idx  <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
          end
          if (!owner_valid || burst_done) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err_overflow <= 1'b0;
    end else if (fifo_overflow) begin
      err_overflow <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else if (beat && (stat_q[grant_idx] != STAT_SAT)) begin
      stat_q[grant_idx] <= stat_q[grant_idx] + STAT_W'(1);
    end
  end

  always_comb begin
    stat_cnt = '0;
    if (32'(stat_sel) < NUM_REQ) begin
      stat_cnt = stat_q[stat_sel];
    end
  end
`endif

endmodule
